// File: rtl/dma_burst_reader.sv
// AXI4 read-only DMA engine: splits a beat-count transfer into INCR bursts of at most
// BURST_LENGTH beats, one outstanding at a time, and streams read data into a ring buffer.
module dma_burst_reader #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BURST_LENGTH = 128,
    parameter int unsigned LEN_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [LEN_WIDTH-1:0]  num_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic                  buf_full,
    output logic                  buf_wen,
    output logic [DATA_WIDTH-1:0] buf_din
);

    localparam int unsigned          Bytes      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BurstBytes = ADDR_WIDTH'(BURST_LENGTH * Bytes);
    localparam logic [LEN_WIDTH-1:0]  BurstBeats = LEN_WIDTH'(BURST_LENGTH);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [8:0]            burst_cnt_q, burst_cnt_d;
    logic                  err_q, err_d;

    logic [LEN_WIDTH-1:0]  beats_this;
    logic                  beat_ok;
    logic                  last_exp;

    always_comb begin
        if (remaining_q >= BurstBeats) begin
            beats_this = BurstBeats;
        end else begin
            beats_this = remaining_q;
        end
    end

    assign m_arlen   = (remaining_q == '0) ? 8'd0 : 8'(beats_this - LEN_WIDTH'(1));
    assign m_araddr  = addr_q;
    assign m_arsize  = 3'($clog2(Bytes));
    assign m_arburst = 2'b01;
    assign m_arvalid = (state_q == StAddr);
    assign m_rready  = (state_q == StData) && !buf_full;
    assign buf_wen   = m_rready && m_rvalid;
    assign buf_din   = m_rdata;
    assign busy      = (state_q == StAddr) || (state_q == StData);
    assign done      = (state_q == StDone);
    assign err       = err_q;

    assign beat_ok  = buf_wen;
    assign last_exp = (burst_cnt_q == 9'd1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burst_cnt_d = burst_cnt_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    if (num_beats != '0) begin
                        addr_d      = src_addr;
                        remaining_d = num_beats;
                        state_d     = StAddr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAddr: begin
                if (m_arready) begin
                    burst_cnt_d = 9'(beats_this);
                    state_d     = StData;
                end
            end
            StData: begin
                if (beat_ok) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    burst_cnt_d = burst_cnt_q - 9'd1;
                    // Our own beat count decides burst end; a wrong rlast only flags err.
                    if ((m_rresp != 2'b00) || (m_rlast != last_exp)) begin
                        err_d = 1'b1;
                    end
                    if (last_exp) begin
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_d = StDone;
                        end else begin
                            // Only the final burst can be short, so any earlier one was full.
                            addr_d  = addr_q + BurstBytes;
                            state_d = StAddr;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            burst_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_cnt_q <= burst_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dma_burst_reader.sv
// Directed bench for dma_burst_reader: a cycle-stepped AXI read slave inside run_xfer plus
// per-scenario tasks comparing burst addresses, lengths, data order, stalls, err and done.
module tb_dma_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [15:0] num_beats;
    logic        busy, done, err;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready;
    logic        buf_full, buf_wen;
    logic [31:0] buf_din;

    int checks   = 0;
    int failures = 0;

    int          ar_cnt, wr_cnt, bad_data, done_cnt, done_cyc, last_wen_cyc;
    int          stall_seen, stall_viol, arvalid_seen, bursts_done;
    logic [31:0] ar_addr [0:7];
    logic [7:0]  ar_len  [0:7];
    int          ar_cyc  [0:7];
    int          bend_cyc[0:7];
    logic        err_at_done;

    dma_burst_reader #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .BURST_LENGTH(128),
        .LEN_WIDTH   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .num_beats(num_beats),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .m_araddr (m_araddr),
        .m_arlen  (m_arlen),
        .m_arsize (m_arsize),
        .m_arburst(m_arburst),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rlast  (m_rlast),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .buf_full (buf_full),
        .buf_wen  (buf_wen),
        .buf_din  (buf_din)
    );

    always #5 clk = ~clk;

    // Runs one transfer against a slave whose data word is 0xA0000000 + beat index.
    // A second start pulse at cycle 5 with a bogus address must be ignored.
    task automatic run_xfer(input logic [31:0] addr, input logic [15:0] n, input int full_at,
                            input int full_len, input int err_beat, input int flip_beat);
        int full_left = 0;
        bit full_used = 0;
        bit in_burst  = 0;
        int beat      = 0;
        int cur_len   = 0;
        bit fin       = 0;
        ar_cnt = 0; wr_cnt = 0; bad_data = 0; done_cnt = 0; done_cyc = -1; last_wen_cyc = -1;
        stall_seen = 0; stall_viol = 0; arvalid_seen = 0; bursts_done = 0; err_at_done = 1'bx;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            start     = (c == 0) || (c == 5);
            src_addr  = (c == 0) ? addr : 32'hDEAD_0000;
            num_beats = (c == 0) ? n : 16'd7;
            if (!full_used && full_len > 0 && wr_cnt == full_at && in_burst) begin
                full_left = full_len;
                full_used = 1;
            end
            buf_full  = (full_left > 0);
            m_arready = 1'b1;
            m_rvalid  = in_burst;
            m_rdata   = 32'hA000_0000 + 32'(wr_cnt);
            m_rlast   = in_burst && (beat == cur_len);
            if (wr_cnt == flip_beat) m_rlast = !m_rlast;
            m_rresp   = (wr_cnt == err_beat) ? 2'b10 : 2'b00;
            #1;
            if (buf_full) begin
                stall_seen++;
                if (m_rready || buf_wen) stall_viol++;
                full_left--;
            end
            if (m_arvalid) begin
                arvalid_seen++;
                if (ar_cnt < 8) begin
                    ar_addr[ar_cnt] = m_araddr;
                    ar_len[ar_cnt]  = m_arlen;
                    ar_cyc[ar_cnt]  = c;
                end
                ar_cnt++;
                in_burst = 1;
                beat     = 0;
                cur_len  = int'(m_arlen);
            end
            if (buf_wen) begin
                if (buf_din !== 32'hA000_0000 + 32'(wr_cnt)) bad_data++;
                wr_cnt++;
                last_wen_cyc = c;
                if (beat == cur_len) begin
                    in_burst = 0;
                    if (bursts_done < 8) bend_cyc[bursts_done] = c;
                    bursts_done++;
                end
                beat++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    err_at_done = err;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) fin = 1;
        end
        if (!fin) $display("FAIL xfer_timeout actual=no_done required=done_within_3000");
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src_addr = '0; num_beats = '0; m_arready = 1'b0;
        m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0; buf_full = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, m_arvalid, m_rready, buf_wen} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=000000",
                     {busy, done, err, m_arvalid, m_rready, buf_wen});
        end
        checks++;
        if (m_araddr !== 32'h0 || m_arlen !== 8'h0) begin
            failures++;
            $display("FAIL reset_ar actual=%h/%h required=00000000/00", m_araddr, m_arlen);
        end
        checks++;
        if (m_arsize !== 3'd2 || m_arburst !== 2'b01) begin
            failures++;
            $display("FAIL ar_consts actual=%0d/%b required=2/01", m_arsize, m_arburst);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        run_xfer(32'h0000_1000, 16'd128, -1, 0, -1, -1);
        checks++;
        if (ar_cnt !== 1 || ar_addr[0] !== 32'h1000 || ar_len[0] !== 8'd127) begin
            failures++;
            $display("FAIL single_ar actual=%0d/%h/%0d required=1/00001000/127",
                     ar_cnt, ar_addr[0], ar_len[0]);
        end
        checks++;
        if (wr_cnt !== 128 || bad_data !== 0) begin
            failures++;
            $display("FAIL single_data actual=%0d/%0d required=128/0", wr_cnt, bad_data);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_wen_cyc + 1) begin
            failures++;
            $display("FAIL single_done actual=%0d@%0d required=1@%0d",
                     done_cnt, done_cyc, last_wen_cyc + 1);
        end
        checks++;
        if (ar_cyc[0] !== 1 || err_at_done !== 1'b0) begin
            failures++;
            $display("FAIL single_timing actual=%0d/%b required=1/0", ar_cyc[0], err_at_done);
        end
    endtask

    task automatic test_multi_burst();
        run_xfer(32'h0, 16'd300, -1, 0, -1, -1);
        checks++;
        if (ar_cnt !== 3 || ar_addr[0] !== 32'h0 || ar_addr[1] !== 32'h200 ||
            ar_addr[2] !== 32'h400) begin
            failures++;
            $display("FAIL multi_addr actual=%0d:%h/%h/%h required=3:0/200/400",
                     ar_cnt, ar_addr[0], ar_addr[1], ar_addr[2]);
        end
        checks++;
        if (ar_len[0] !== 8'd127 || ar_len[1] !== 8'd127 || ar_len[2] !== 8'd43) begin
            failures++;
            $display("FAIL multi_len actual=%0d/%0d/%0d required=127/127/43",
                     ar_len[0], ar_len[1], ar_len[2]);
        end
        checks++;
        if (wr_cnt !== 300 || bad_data !== 0 || done_cnt !== 1) begin
            failures++;
            $display("FAIL multi_data actual=%0d/%0d/%0d required=300/0/1",
                     wr_cnt, bad_data, done_cnt);
        end
        checks++;
        if (ar_cyc[1] !== bend_cyc[0] + 1 || ar_cyc[2] !== bend_cyc[1] + 1) begin
            failures++;
            $display("FAIL multi_ar_gap actual=%0d,%0d required=%0d,%0d",
                     ar_cyc[1], ar_cyc[2], bend_cyc[0] + 1, bend_cyc[1] + 1);
        end
    endtask

    task automatic test_addr_wrap();
        run_xfer(32'hFFFF_FE00, 16'd256, -1, 0, -1, -1);
        checks++;
        if (ar_cnt !== 2 || ar_addr[0] !== 32'hFFFF_FE00 || ar_addr[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr actual=%0d:%h/%h required=2:fffffe00/00000000",
                     ar_cnt, ar_addr[0], ar_addr[1]);
        end
    endtask

    task automatic test_backpressure();
        run_xfer(32'h0000_2000, 16'd128, 40, 5, -1, -1);
        checks++;
        if (stall_seen !== 5 || stall_viol !== 0) begin
            failures++;
            $display("FAIL stall actual=%0d/%0d required=5/0", stall_seen, stall_viol);
        end
        checks++;
        if (wr_cnt !== 128 || bad_data !== 0 || done_cnt !== 1) begin
            failures++;
            $display("FAIL stall_data actual=%0d/%0d/%0d required=128/0/1",
                     wr_cnt, bad_data, done_cnt);
        end
        checks++;
        if (last_wen_cyc !== 134) begin
            failures++;
            $display("FAIL stall_len actual=%0d required=134", last_wen_cyc);
        end
    endtask

    task automatic test_err_resp();
        run_xfer(32'h0000_8000, 16'd20, -1, 0, 4, -1);
        checks++;
        if (wr_cnt !== 20 || bad_data !== 0 || done_cnt !== 1 || err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL resp_err actual=%0d/%0d/%0d/%b required=20/0/1/1",
                     wr_cnt, bad_data, done_cnt, err_at_done);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky actual=%b required=1", err);
        end
        run_xfer(32'h0000_9000, 16'd4, -1, 0, -1, -1);
        checks++;
        if (err_at_done !== 1'b0 || wr_cnt !== 4) begin
            failures++;
            $display("FAIL err_clear actual=%b/%0d required=0/4", err_at_done, wr_cnt);
        end
    endtask

    task automatic test_rlast_mismatch();
        run_xfer(32'h0000_A000, 16'd8, -1, 0, -1, 2);
        checks++;
        if (wr_cnt !== 8 || done_cnt !== 1 || err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL rlast_err actual=%0d/%0d/%b required=8/1/1",
                     wr_cnt, done_cnt, err_at_done);
        end
    endtask

    task automatic test_zero_len();
        run_xfer(32'h0000_5000, 16'd0, -1, 0, -1, -1);
        checks++;
        if (arvalid_seen !== 0 || wr_cnt !== 0) begin
            failures++;
            $display("FAIL zero_ar actual=%0d/%0d required=0/0", arvalid_seen, wr_cnt);
        end
        checks++;
        if (done_cyc !== 1 || done_cnt !== 1) begin
            failures++;
            $display("FAIL zero_done actual=%0d@%0d required=1@1", done_cnt, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; src_addr = 32'h3000; num_beats = 16'd64;
        m_arready = 1'b1; m_rvalid = 1'b0; buf_full = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rlast = 1'b0; m_rresp = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b1 || m_rready !== 1'b1 || buf_wen !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre actual=%b%b%b required=111", busy, m_rready, buf_wen);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_arvalid, m_rready, busy, buf_wen, done, err} !== 6'b0 || m_araddr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset actual=%b/%h required=000000/00000000",
                     {m_arvalid, m_rready, busy, buf_wen, done, err}, m_araddr);
        end
        @(negedge clk);
        rst = 1'b0; m_rvalid = 1'b0;
        run_xfer(32'h0000_4000, 16'd16, -1, 0, -1, -1);
        checks++;
        if (ar_cnt !== 1 || ar_addr[0] !== 32'h4000 || ar_len[0] !== 8'd15) begin
            failures++;
            $display("FAIL post_reset_ar actual=%0d/%h/%0d required=1/00004000/15",
                     ar_cnt, ar_addr[0], ar_len[0]);
        end
        checks++;
        if (wr_cnt !== 16 || bad_data !== 0 || done_cnt !== 1) begin
            failures++;
            $display("FAIL post_reset_data actual=%0d/%0d/%0d required=16/0/1",
                     wr_cnt, bad_data, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_addr_wrap();
        test_backpressure();
        test_err_resp();
        test_rlast_mismatch();
        test_zero_len();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_burst_reader.md
DMA_BURST_READER -- requirements
Module: dma_burst_reader

Interface
REQ-001 DATA_WIDTH, 32, read data width and buffer word width.
REQ-002 ADDR_WIDTH, 32, byte address width.
REQ-003 BURST_LENGTH, 128, max beats per AXI4 read burst; power of two, 1..256.
REQ-004 LEN_WIDTH, 16, width of the transfer length field in beats.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  transfer request; sampled only in IDLE.
REQ-008 src_addr  input  ADDR_WIDTH  start byte address; must be aligned to BURST_LENGTH*DATA_WIDTH/8.
REQ-009 num_beats  input  LEN_WIDTH  total beats to transfer; sampled with start.
REQ-010 busy  output  1  high in ADDR and DATA states.
REQ-011 done  output  1  one-cycle pulse at transfer end.
REQ-012 err  output  1  sticky error flag.
REQ-013 m_araddr  output  ADDR_WIDTH  AR burst address.
REQ-014 m_arlen  output  8  AR beats minus one.
REQ-015 m_arsize  output  3  constant log2(DATA_WIDTH/8).
REQ-016 m_arburst  output  2  constant 2'b01 (INCR).
REQ-017 m_arvalid  output  1  AR valid.
REQ-018 m_arready  input  1  AR ready.
REQ-019 m_rdata  input  DATA_WIDTH  read data.
REQ-020 m_rresp  input  2  read response.
REQ-021 m_rlast  input  1  last beat of burst.
REQ-022 m_rvalid  input  1  R valid.
REQ-023 m_rready  output  1  R ready.
REQ-024 buf_full  input  1  downstream ring buffer full flag.
REQ-025 buf_wen  output  1  ring buffer write enable.
REQ-026 buf_din  output  DATA_WIDTH  ring buffer write data.

Function
REQ-027 FSM SHALL have states IDLE, ADDR, DATA, DONE.
REQ-028 IDLE: start=1, num_beats>0 -> latch src_addr, remaining=num_beats, clear err, go ADDR; start=1, num_beats=0 -> go DONE, no AR issued, err cleared; start outside IDLE SHALL be ignored.
REQ-029 ADDR: m_arvalid=1; m_araddr=current address; m_arlen=min(remaining,BURST_LENGTH)-1; both held stable until m_arvalid&&m_arready, then go DATA with burst_cnt=m_arlen+1.
REQ-030 m_arvalid SHALL be 0 outside ADDR; m_rready SHALL be 0 outside DATA.
REQ-031 DATA: m_rready = !buf_full (combinational); beat accepted when m_rvalid&&m_rready.
REQ-032 On accepted beat, buf_wen=1 and buf_din=m_rdata in the same cycle; buf_wen SHALL be 0 otherwise; buf_full high SHALL stall with no beat lost or duplicated.
REQ-033 Each accepted beat SHALL decrement remaining and burst_cnt.
REQ-034 Last beat of burst (burst_cnt=1): remaining becomes 0 -> DONE; else address += (m_arlen+1)*DATA_WIDTH/8, go ADDR; m_arvalid SHALL be asserted the cycle after that beat.
REQ-035 At most one burst outstanding.
REQ-036 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-037 DONE: done=1 for exactly one cycle, then IDLE.
REQ-038 err SHALL set on any accepted beat with m_rresp!=2'b00, or m_rlast mismatching the internal last-beat expectation; beat count stays authoritative and the transfer SHALL complete normally; err holds until next accepted start.

Reset
REQ-039 rst assertion SHALL immediately force IDLE, counters 0, m_araddr 0, m_arlen 0, m_arvalid/m_rready/buf_wen/busy/done/err 0.
REQ-040 Reset mid-burst SHALL abandon the transfer; a new start after release SHALL operate normally.

Verification
REQ-041 num_beats=128, src_addr=0x1000, arready/rvalid always 1, buf_full=0 -> one AR (araddr 0x1000, arlen 127), 128 in-order buf_wen pulses, done one cycle after the last beat.
REQ-042 num_beats=300, src_addr=0 -> three ARs: araddr 0x000/0x200/0x400, arlen 127/127/43; 300 writes total; one done.
REQ-043 buf_full high for 5 cycles mid-burst -> m_rready and buf_wen 0 for those cycles; all 128 words delivered in order.
REQ-044 m_rresp=2'b10 on beat 5 -> all beats still written, err=1 at done; next start clears err.
REQ-045 num_beats=0 -> m_arvalid never asserted, done pulses the cycle after start.
REQ-046 rst asserted during DATA -> m_arvalid, m_rready, busy and buf_wen 0 in the same cycle; a subsequent 16-beat transfer completes correctly.
